// File: rtl/control_sequencer.sv
// control_sequencer: T-state ring counter and opcode decoder for an 8-bit bus computer.
// It drives the load and drive strobes of the PC, MAR, RAM, IR, A, ALU, B and OUT registers.
// Only one register drives the shared bus in any cycle.
//
// Ports:
//   clk     system clock, rising edge
//   clr     asynchronous active-high reset: T0, not halted
//   opcode  IR upper nibble, decoded in T3..T5
//   hold    pause: T-state frozen, all strobes idle
//   POb MIb ROb IIb IOb AIb AOb BIb SOb OIb   active-low strobes
//   PCE SU  active-high strobes (PC increment, ALU subtract)
//   halted  set once HLT executes, cleared only by clr
//   tstate  one-hot T-state, bit0 = T0
//
// Strobes are a combinational decode of tstate/opcode/hold/halted.
// Target registers consume them on the next rising edge.
//
// Build option: define SEQ_EARLY_END_EN to return to T0 after the last useful
// T-state of each instruction (NOP/OUT after T3, LDA after T4).
module control_sequencer #(
    parameter int unsigned T_STATES = 6,
    parameter int unsigned OPC_W    = 4
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [OPC_W-1:0]    opcode,
    input  logic                hold,
    output logic                POb,
    output logic                PCE,
    output logic                MIb,
    output logic                ROb,
    output logic                IIb,
    output logic                IOb,
    output logic                AIb,
    output logic                AOb,
    output logic                BIb,
    output logic                SOb,
    output logic                SU,
    output logic                OIb,
    output logic                halted,
    output logic [T_STATES-1:0] tstate
);

    localparam logic [T_STATES-1:0] T0 = T_STATES'(6'b000001);
    localparam logic [T_STATES-1:0] T1 = T_STATES'(6'b000010);
    localparam logic [T_STATES-1:0] T2 = T_STATES'(6'b000100);
    localparam logic [T_STATES-1:0] T3 = T_STATES'(6'b001000);
    localparam logic [T_STATES-1:0] T4 = T_STATES'(6'b010000);
    localparam logic [T_STATES-1:0] T5 = T_STATES'(6'b100000);

    localparam logic [OPC_W-1:0] OP_LDA = OPC_W'(4'b0000);
    localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(4'b0001);
    localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(4'b0010);
    localparam logic [OPC_W-1:0] OP_OUT = OPC_W'(4'b1110);
    localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(4'b1111);

    logic [T_STATES-1:0] tstate_nx;
    logic                halted_nx;
    logic                is_lda, is_add, is_sub, is_out, is_hlt, is_nop;
    logic                run;
    logic                last_state;

    // Opcode class decode
    always_comb begin
        is_lda = (opcode == OP_LDA);
        is_add = (opcode == OP_ADD);
        is_sub = (opcode == OP_SUB);
        is_out = (opcode == OP_OUT);
        is_hlt = (opcode == OP_HLT);
        is_nop = !(is_lda || is_add || is_sub || is_out || is_hlt);
        run    = !hold && !halted;
    end

    // State register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            tstate <= T0;
            halted <= 1'b0;
        end else begin
            tstate <= tstate_nx;
            halted <= halted_nx;
        end
    end

    // Next-state: rotate the ring, freeze on hold/halt, park at T3 on HLT
    always_comb begin
        tstate_nx = tstate;
        halted_nx = halted;
`ifdef SEQ_EARLY_END_EN
        last_state = ((tstate == T3) && (is_nop || is_out)) ||
                     ((tstate == T4) && is_lda);
`else
        last_state = 1'b0;
`endif
        if (run) begin
            if ((tstate == T3) && is_hlt) begin
                halted_nx = 1'b1;
            end else if (last_state) begin
                tstate_nx = T0;
            end else begin
                tstate_nx = {tstate[T_STATES-2:0], tstate[T_STATES-1]};
            end
        end
    end

    // Strobe decode; the idle word is the default and is forced by hold/halted
    always_comb begin
        POb = 1'b1;
        PCE = 1'b0;
        MIb = 1'b1;
        ROb = 1'b1;
        IIb = 1'b1;
        IOb = 1'b1;
        AIb = 1'b1;
        AOb = 1'b1;
        BIb = 1'b1;
        SOb = 1'b1;
        SU  = 1'b0;
        OIb = 1'b1;
        if (run) begin
            case (tstate)
                T0: begin
                    POb = 1'b0;
                    MIb = 1'b0;
                end
                T1: PCE = 1'b1;
                T2: begin
                    ROb = 1'b0;
                    IIb = 1'b0;
                end
                T3: begin
                    if (is_lda || is_add || is_sub) begin
                        IOb = 1'b0;
                        MIb = 1'b0;
                    end else if (is_out) begin
                        AOb = 1'b0;
                        OIb = 1'b0;
                    end
                end
                T4: begin
                    if (is_lda) begin
                        ROb = 1'b0;
                        AIb = 1'b0;
                    end else if (is_add || is_sub) begin
                        ROb = 1'b0;
                        BIb = 1'b0;
                    end
                end
                T5: begin
                    if (is_add || is_sub) begin
                        SOb = 1'b0;
                        AIb = 1'b0;
                        SU  = is_sub;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer with a scoreboard.
// The stimulus process drives one input set per cycle. It pushes the expected tstate, halted and
// active-strobe set, taken from a step-counter model, into a queue.
// A monitor pops one entry at each falling edge and compares it with the DUT.
module tb_control_sequencer;

    localparam int B_PO = 11, B_PCE = 10, B_MI = 9, B_RO = 8, B_II = 7, B_IO = 6;
    localparam int B_AI = 5,  B_AO  = 4,  B_BI = 3, B_SO = 2, B_SU = 1, B_OI = 0;

    typedef struct {
        logic [5:0]  ts;
        logic        hl;
        logic [11:0] act;
    } exp_t;

    logic       clk;
    logic       clr;
    logic [3:0] opcode;
    logic       hold;
    logic       POb, PCE, MIb, ROb, IIb, IOb, AIb, AOb, BIb, SOb, SU, OIb;
    logic       halted;
    logic [5:0] tstate;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    int   m_step;
    logic m_halt;

    control_sequencer dut (
        .clk(clk), .clr(clr), .opcode(opcode), .hold(hold),
        .POb(POb), .PCE(PCE), .MIb(MIb), .ROb(ROb), .IIb(IIb), .IOb(IOb),
        .AIb(AIb), .AOb(AOb), .BIb(BIb), .SOb(SOb), .SU(SU), .OIb(OIb),
        .halted(halted), .tstate(tstate)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction table: which strobes are asserted in each step
    function automatic logic [11:0] exp_act(int step, logic [3:0] op, logic hd, logic hl);
        logic [11:0] a;
        a = '0;
        if (hd || hl) return a;
        case (step)
            0: begin a[B_PO] = 1'b1; a[B_MI] = 1'b1; end
            1: a[B_PCE] = 1'b1;
            2: begin a[B_RO] = 1'b1; a[B_II] = 1'b1; end
            3: begin
                if (op == 4'h0 || op == 4'h1 || op == 4'h2) begin
                    a[B_IO] = 1'b1; a[B_MI] = 1'b1;
                end else if (op == 4'hE) begin
                    a[B_AO] = 1'b1; a[B_OI] = 1'b1;
                end
            end
            4: begin
                if (op == 4'h0) begin
                    a[B_RO] = 1'b1; a[B_AI] = 1'b1;
                end else if (op == 4'h1 || op == 4'h2) begin
                    a[B_RO] = 1'b1; a[B_BI] = 1'b1;
                end
            end
            5: begin
                if (op == 4'h1 || op == 4'h2) begin
                    a[B_SO] = 1'b1; a[B_AI] = 1'b1; a[B_SU] = (op == 4'h2);
                end
            end
            default: ;
        endcase
        return a;
    endfunction

    // Index of the final step of an instruction before the ring wraps
    function automatic int last_step(logic [3:0] op);
`ifdef SEQ_EARLY_END_EN
        if (op == 4'h1 || op == 4'h2) return 5;
        if (op == 4'h0) return 4;
        return 3;
`else
        if (op == 4'hF) return 5;
        return 5;
`endif
    endfunction

    function automatic logic [3:0] pick_opcode();
        case ($urandom_range(0, 7))
            0: return 4'h0;
            1: return 4'h1;
            2: return 4'h2;
            3: return 4'hE;
            4: return 4'hF;
            default: return 4'($urandom_range(0, 15));
        endcase
    endfunction

    function automatic exp_t make_exp();
        exp_t e;
        e.ts  = 6'(1) << m_step;
        e.hl  = m_halt;
        e.act = exp_act(m_step, opcode, hold, m_halt);
        return e;
    endfunction

    // Stimulus and reference model
    initial begin
        clr    = 1'b0;
        hold   = 1'b0;
        opcode = 4'h0;
        m_step = 0;
        m_halt = 1'b0;
        #2 clr = 1'b1;
        #1 exp_q.push_back(make_exp());
        repeat (2) @(posedge clk);
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            if (m_step == 0 && !m_halt) opcode = pick_opcode();
            hold = ($urandom_range(0, 4) == 0);
            clr  = ($urandom_range(0, 39) == 0);
            if (clr) begin
                m_step = 0;
                m_halt = 1'b0;
            end
            exp_q.push_back(make_exp());
            if (!clr && !hold && !m_halt) begin
                if (m_step == 3 && opcode == 4'hF) m_halt = 1'b1;
                else if (m_step == last_step(opcode)) m_step = 0;
                else m_step = m_step + 1;
            end
        end
        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Monitor: compare one scoreboard entry per cycle, plus the bus-contention rule
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t        e;
            logic [11:0] got;
            e   = exp_q.pop_front();
            got = {~POb, PCE, ~MIb, ~ROb, ~IIb, ~IOb, ~AIb, ~AOb, ~BIb, ~SOb, SU, ~OIb};
            checks++;
            if (tstate !== e.ts) begin
                failures++;
                $display("FAIL tstate t=%0t got=%b exp=%b", $time, tstate, e.ts);
            end
            checks++;
            if (halted !== e.hl) begin
                failures++;
                $display("FAIL halted t=%0t got=%b exp=%b", $time, halted, e.hl);
            end
            checks++;
            if (got !== e.act) begin
                failures++;
                $display("FAIL strobes t=%0t op=%h hold=%b got=%b exp=%b",
                         $time, opcode, hold, got, e.act);
            end
        end
        checks++;
        if ($countones({~POb, ~ROb, ~IOb, ~AOb, ~SOb}) > 1) begin
            failures++;
            $display("FAIL bus_drivers t=%0t got=%b exp=at most one low",
                     $time, {POb, ROb, IOb, AOb, SOb});
        end
    end

endmodule
